video_timing_tracker: RTL and testbench

Sits directly downstream of the video pattern/timing generator, between it and the HDMI transmitter pins. Registers the DE/HS/VS/RGB stream one cycle and annotates it with pixel coordinates (x, y) plus line-start and frame-start strobes. Measures active width and height of every line and frame against the expected 640x480 geometry and runs a lock state machine. Downstream overlay logic and the HPS status registers rely on `locked`, the error pulses and the coordinates.

---
 rtl/video_timing_tracker.sv | 221 ++++++++++++++++++++++
 tb/tb_video_timing_tracker.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_tracker.sv
// Registers the DE/HS/VS/RGB stream one cycle, annotates it with pixel coordinates and
// line/frame strobes, and checks the geometry of every line and frame to drive a lock FSM.
module video_timing_tracker #(
  parameter int H_ACTIVE      = 640,
  parameter int V_ACTIVE      = 480,
  parameter bit VS_ACTIVE_LOW = 1'b1,
  parameter int LOCK_FRAMES   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_de,
  input  logic        in_hs,
  input  logic        in_vs,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        out_de,
  output logic        out_hs,
  output logic        out_vs,
  output logic [7:0]  out_r,
  output logic [7:0]  out_g,
  output logic [7:0]  out_b,
  output logic [11:0] out_x,
  output logic [11:0] out_y,
  output logic        line_start,
  output logic        frame_start,
  output logic        locked,
  output logic        err_width,
  output logic        err_height,
  output logic [11:0] meas_width,
  output logic [11:0] meas_height
);

  typedef enum logic [1:0] {SEARCH = 2'd0, SYNC = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [11:0] CNT_MAX = 12'hFFF;
  localparam logic [11:0] H_ACT   = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT   = 12'(V_ACTIVE);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic        line_start_q, line_start_d, frame_start_q, frame_start_d;
  logic        first_line_q, first_line_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic        bad_frame_q, bad_frame_d;
  logic [11:0] meas_width_q, meas_width_d, meas_height_q, meas_height_d;
  logic        err_width_q, err_width_d, err_height_q, err_height_d;
  state_t      state_q, state_d;
  logic [3:0]  good_cnt_q, good_cnt_d;
  logic        locked_q, locked_d;

  logic        vs_asserted_in, vs_asserted_q;
  logic        de_rise, de_fall, vs_edge, new_frame_line;
  logic [11:0] line_width;
  logic        width_bad, frame_good;

  always_comb begin
    vs_asserted_in = VS_ACTIVE_LOW ? ~in_vs : in_vs;
    vs_asserted_q  = VS_ACTIVE_LOW ? ~vs_q : vs_q;
    de_rise        = in_de & ~de_q;
    de_fall        = ~in_de & de_q;
    vs_edge        = vs_asserted_in & ~vs_asserted_q;
    // A rise coincident with the VS edge already belongs to the new frame.
    new_frame_line = first_line_q | vs_edge;
    line_width     = (x_q == CNT_MAX) ? CNT_MAX : x_q + 12'd1;
    width_bad      = de_fall && (line_width != H_ACT) && (state_q != SEARCH);
    frame_good     = (line_cnt_q == V_ACT) && !bad_frame_q && !width_bad;
  end

  always_comb begin
    de_d          = in_de;
    hs_d          = in_hs;
    vs_d          = in_vs;
    r_d           = in_r;
    g_d           = in_g;
    b_d           = in_b;
    x_d           = x_q;
    y_d           = y_q;
    line_start_d  = de_rise;
    frame_start_d = de_rise & new_frame_line;
    first_line_d  = first_line_q;
    line_cnt_d    = line_cnt_q;
    bad_frame_d   = bad_frame_q | width_bad;
    meas_width_d  = meas_width_q;
    meas_height_d = meas_height_q;
    // A short line ending on the VS edge is reported only through the frame verdict.
    err_width_d   = width_bad & ~vs_edge;
    err_height_d  = vs_edge && (line_cnt_q != V_ACT) && (state_q != SEARCH);

    if (de_rise) begin
      x_d = 12'd0;
      if (new_frame_line) begin
        y_d          = 12'd0;
        first_line_d = 1'b0;
      end else if (y_q != CNT_MAX) begin
        y_d = y_q + 12'd1;
      end
    end else if (in_de && de_q && (x_q != CNT_MAX)) begin
      x_d = x_q + 12'd1;
    end
    if (vs_edge && !de_rise) begin
      first_line_d = 1'b1;
    end

    if (de_fall) begin
      meas_width_d = line_width;
    end

    if (vs_edge) begin
      meas_height_d = line_cnt_q;
      line_cnt_d    = de_rise ? 12'd1 : 12'd0;
      bad_frame_d   = 1'b0;
    end else if (de_rise && (line_cnt_q != CNT_MAX)) begin
      line_cnt_d = line_cnt_q + 12'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    case (state_q)
      SEARCH: begin
        if (vs_edge) begin
          state_d    = SYNC;
          good_cnt_d = 4'd0;
        end
      end
      SYNC: begin
        if (vs_edge) begin
          if (frame_good) begin
            good_cnt_d = good_cnt_q + 4'd1;
            if (good_cnt_q + 4'd1 == LOCK_N) begin
              state_d = LOCKED;
            end
          end else begin
            good_cnt_d = 4'd0;
          end
        end
      end
      LOCKED: begin
        if (width_bad || (vs_edge && !frame_good)) begin
          state_d    = SYNC;
          good_cnt_d = 4'd0;
        end
      end
      default: begin
        state_d    = SEARCH;
        good_cnt_d = 4'd0;
      end
    endcase
  end

  always_comb begin
    locked_d = (state_q == LOCKED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      de_q          <= 1'b0;
      hs_q          <= 1'b0;
      vs_q          <= 1'b0;
      r_q           <= 8'd0;
      g_q           <= 8'd0;
      b_q           <= 8'd0;
      x_q           <= 12'd0;
      y_q           <= 12'd0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      first_line_q  <= 1'b0;
      line_cnt_q    <= 12'd0;
      bad_frame_q   <= 1'b0;
      meas_width_q  <= 12'd0;
      meas_height_q <= 12'd0;
      err_width_q   <= 1'b0;
      err_height_q  <= 1'b0;
      state_q       <= SEARCH;
      good_cnt_q    <= 4'd0;
      locked_q      <= 1'b0;
    end else begin
      de_q          <= de_d;
      hs_q          <= hs_d;
      vs_q          <= vs_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
      x_q           <= x_d;
      y_q           <= y_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      first_line_q  <= first_line_d;
      line_cnt_q    <= line_cnt_d;
      bad_frame_q   <= bad_frame_d;
      meas_width_q  <= meas_width_d;
      meas_height_q <= meas_height_d;
      err_width_q   <= err_width_d;
      err_height_q  <= err_height_d;
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      locked_q      <= locked_d;
    end
  end

  assign out_de      = de_q;
  assign out_hs      = hs_q;
  assign out_vs      = vs_q;
  assign out_r       = r_q;
  assign out_g       = g_q;
  assign out_b       = b_q;
  assign out_x       = x_q;
  assign out_y       = y_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign locked      = locked_q;
  assign err_width   = err_width_q;
  assign err_height  = err_height_q;
  assign meas_width  = meas_width_q;
  assign meas_height = meas_height_q;

endmodule

// File: tb/tb_video_timing_tracker.sv
// Bench for video_timing_tracker on a shrunken 8x4 geometry: a reset-state vector table,
// hand-written lock/unlock scenarios, and random streams checked against a frame-level model.
module tb_video_timing_tracker;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int LF = 2;
  localparam bit VSL = 1'b1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_de, in_hs, in_vs;
  logic [7:0]  in_r, in_g, in_b;
  logic        out_de, out_hs, out_vs;
  logic [7:0]  out_r, out_g, out_b;
  logic [11:0] out_x, out_y, meas_width, meas_height;
  logic        line_start, frame_start, locked, err_width, err_height;

  video_timing_tracker #(
    .H_ACTIVE(H), .V_ACTIVE(V), .VS_ACTIVE_LOW(VSL), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .reset(reset),
    .in_de(in_de), .in_hs(in_hs), .in_vs(in_vs),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_x(out_x), .out_y(out_y),
    .line_start(line_start), .frame_start(frame_start), .locked(locked),
    .err_width(err_width), .err_height(err_height),
    .meas_width(meas_width), .meas_height(meas_height)
  );

  int checks = 0;
  int errors = 0;
  int ew_cnt = 0;
  int eh_cnt = 0;
  int last_ew_mw = 0;

  // Reference model state, expressed as run lengths and per-frame tallies.
  bit       m_de, m_hs, m_vs, m_ls, m_fs, m_ew, m_eh, m_locked;
  bit [7:0] m_r, m_g, m_b;
  int       m_x, m_y, m_mw, m_mh;
  bit       prev_de, prev_vs, have_vs;
  int       run_len, rises_total, rises_frame, frame_werr, level;

  typedef struct {
    bit rst; bit de; bit vs; bit [7:0] r;
    bit e_de; bit e_vs; bit [7:0] e_r; int e_x; int e_y;
    bit e_ls; bit e_fs; bit e_ew; int e_mw; bit e_eh; int e_mh;
  } vec_t;

  vec_t tbl[11];

  function automatic int minI(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic checkVal(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelStep();
    bit rise, fall, vsa, pvsa, vedge, searching, wbad, good;
    int width, lines;
    if (reset) begin
      {m_de, m_hs, m_vs, m_ls, m_fs, m_ew, m_eh, m_locked} = '0;
      m_r = 0; m_g = 0; m_b = 0;
      m_x = 0; m_y = 0; m_mw = 0; m_mh = 0;
      prev_de = 0; prev_vs = 0; have_vs = 0;
      run_len = 0; rises_total = 0; rises_frame = 0; frame_werr = 0; level = -1;
    end else begin
      rise  = in_de && !prev_de;
      fall  = !in_de && prev_de;
      vsa   = VSL ? !in_vs : in_vs;
      pvsa  = VSL ? !prev_vs : prev_vs;
      vedge = vsa && !pvsa;
      searching = (level < 0);
      m_locked = (level == LF);
      m_ls = rise; m_fs = 0; m_ew = 0; m_eh = 0;
      if (rise) run_len = 1;
      else if (in_de) run_len++;
      if (run_len > 0) m_x = minI(run_len - 1, 4095);
      width = minI(run_len, 4095);
      wbad  = fall && (width != H) && !searching;
      if (fall) m_mw = width;
      m_ew = wbad && !vedge;
      if (vedge) begin
        lines = minI(rises_frame, 4095);
        m_mh  = lines;
        m_eh  = (lines != V) && !searching;
        good  = (lines == V) && (frame_werr == 0) && !wbad;
        if (searching || !good) level = 0;
        else if (level < LF) level++;
        frame_werr = 0;
        rises_frame = 0;
        have_vs = 1;
      end else begin
        if (wbad) frame_werr++;
        if (wbad && level == LF) level = 0;
      end
      if (rise) begin
        rises_frame++;
        rises_total++;
        if (have_vs) begin
          m_y  = minI(rises_frame - 1, 4095);
          m_fs = (rises_frame == 1);
        end else begin
          m_y = minI(rises_total, 4095);
        end
      end
      m_de = in_de; m_hs = in_hs; m_vs = in_vs;
      m_r = in_r; m_g = in_g; m_b = in_b;
      prev_de = in_de; prev_vs = in_vs;
    end
  endtask

  task automatic checkOutput();
    checkVal("out_de", int'(out_de), int'(m_de));
    checkVal("out_hs", int'(out_hs), int'(m_hs));
    checkVal("out_vs", int'(out_vs), int'(m_vs));
    checkVal("out_r", int'(out_r), int'(m_r));
    checkVal("out_g", int'(out_g), int'(m_g));
    checkVal("out_b", int'(out_b), int'(m_b));
    checkVal("out_x", int'(out_x), m_x);
    checkVal("out_y", int'(out_y), m_y);
    checkVal("line_start", int'(line_start), int'(m_ls));
    checkVal("frame_start", int'(frame_start), int'(m_fs));
    checkVal("locked", int'(locked), int'(m_locked));
    checkVal("err_width", int'(err_width), int'(m_ew));
    checkVal("err_height", int'(err_height), int'(m_eh));
    checkVal("meas_width", int'(meas_width), m_mw);
    checkVal("meas_height", int'(meas_height), m_mh);
  endtask

  task automatic applyStimulus(input bit rst, input bit de, input bit vs, input bit [7:0] r);
    reset = rst; in_de = de; in_vs = vs; in_r = r;
    in_hs = ($urandom_range(0, 1) == 1);
    in_g  = 8'($urandom);
    in_b  = 8'($urandom);
    @(posedge clk);
    #1;
    modelStep();
    checkOutput();
    if (err_width) begin
      ew_cnt++;
      last_ew_mw = int'(meas_width);
    end
    if (err_height) eh_cnt++;
  endtask

  task automatic sendLine(input int len, input int gap);
    for (int i = 0; i < len; i++) applyStimulus(1'b0, 1'b1, 1'b1, 8'($urandom));
    for (int i = 0; i < gap; i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
  endtask

  // Active lines first, then the VS pulse; the VS edge lands on the first VS-low cycle.
  task automatic sendFrame(input int n_lines, input int bad_line, input int bad_len, input bit coincide);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
    for (int l = 0; l < n_lines; l++) begin
      sendLine((l == bad_line) ? bad_len : H, (coincide && l == n_lines - 1) ? 0 : 3);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
    applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
  endtask

  task automatic randomFrame();
    int pick, n, len, gap;
    pick = int'($urandom_range(0, 9));
    n = (pick == 6) ? V - 1 : (pick == 7) ? V + 1 : (pick == 8) ? int'($urandom_range(0, 6)) : V;
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
    for (int l = 0; l < n; l++) begin
      len = ($urandom_range(0, 9) < 8) ? H : int'($urandom_range(1, 12));
      gap = (l == n - 1 && $urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 4));
      sendLine(len, gap);
    end
    for (int i = 0; i < int'($urandom_range(1, 3)); i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < int'($urandom_range(1, 4)); i++) applyStimulus(1'b0, 1'b0, 1'b1, 8'($urandom));
  endtask

  initial begin
    reset = 1'b1; in_de = 0; in_hs = 0; in_vs = 1; in_r = 0; in_g = 0; in_b = 0;

    //            rst de vs r       | de vs r      x  y  ls fs ew mw eh mh
    tbl[0]  = '{1'b1, 0, 1, 8'h11, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1'b0, 0, 1, 8'h22, 0, 1, 8'h22, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1'b0, 0, 0, 8'h33, 0, 0, 8'h33, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[3]  = '{1'b0, 0, 1, 8'h44, 0, 1, 8'h44, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4]  = '{1'b0, 1, 1, 8'h55, 1, 1, 8'h55, 0, 0, 1, 1, 0, 0, 0, 0};
    tbl[5]  = '{1'b0, 1, 1, 8'h66, 1, 1, 8'h66, 1, 0, 0, 0, 0, 0, 0, 0};
    tbl[6]  = '{1'b0, 0, 1, 8'h77, 0, 1, 8'h77, 1, 0, 0, 0, 1, 2, 0, 0};
    tbl[7]  = '{1'b0, 1, 1, 8'h88, 1, 1, 8'h88, 0, 1, 1, 0, 0, 2, 0, 0};
    tbl[8]  = '{1'b0, 0, 1, 8'h99, 0, 1, 8'h99, 0, 1, 0, 0, 1, 1, 0, 0};
    tbl[9]  = '{1'b0, 0, 0, 8'hAA, 0, 0, 8'hAA, 0, 1, 0, 0, 0, 1, 1, 2};
    tbl[10] = '{1'b0, 1, 0, 8'hBB, 1, 0, 8'hBB, 0, 0, 1, 1, 0, 1, 0, 2};

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].de, tbl[i].vs, tbl[i].r);
      checkVal($sformatf("tbl%0d_de", i), int'(out_de), int'(tbl[i].e_de));
      checkVal($sformatf("tbl%0d_vs", i), int'(out_vs), int'(tbl[i].e_vs));
      checkVal($sformatf("tbl%0d_r", i), int'(out_r), int'(tbl[i].e_r));
      checkVal($sformatf("tbl%0d_x", i), int'(out_x), tbl[i].e_x);
      checkVal($sformatf("tbl%0d_y", i), int'(out_y), tbl[i].e_y);
      checkVal($sformatf("tbl%0d_ls", i), int'(line_start), int'(tbl[i].e_ls));
      checkVal($sformatf("tbl%0d_fs", i), int'(frame_start), int'(tbl[i].e_fs));
      checkVal($sformatf("tbl%0d_ew", i), int'(err_width), int'(tbl[i].e_ew));
      checkVal($sformatf("tbl%0d_mw", i), int'(meas_width), tbl[i].e_mw);
      checkVal($sformatf("tbl%0d_eh", i), int'(err_height), int'(tbl[i].e_eh));
      checkVal($sformatf("tbl%0d_mh", i), int'(meas_height), tbl[i].e_mh);
    end

    $display("[TB] clean stream and lock acquisition");
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    ew_cnt = 0; eh_cnt = 0;
    sendFrame(V, -1, 0, 1'b0);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("locked_after_2_edges", int'(locked), 0);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("locked_after_3_edges", int'(locked), 1);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("clean_err_width_pulses", ew_cnt, 0);
    checkVal("clean_err_height_pulses", eh_cnt, 0);
    checkVal("clean_meas_width", int'(meas_width), H);
    checkVal("clean_meas_height", int'(meas_height), V);

    $display("[TB] short line while locked");
    ew_cnt = 0;
    sendFrame(V, 1, H - 1, 1'b0);
    checkVal("short_line_pulses", ew_cnt, 1);
    checkVal("short_line_meas_width", last_ew_mw, H - 1);
    checkVal("short_line_unlocked", int'(locked), 0);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("short_line_relock_1", int'(locked), 0);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("short_line_relock_2", int'(locked), 1);

    $display("[TB] short frame while locked");
    eh_cnt = 0;
    sendFrame(V - 1, -1, 0, 1'b0);
    checkVal("short_frame_pulses", eh_cnt, 1);
    checkVal("short_frame_meas_height", int'(meas_height), V - 1);
    checkVal("short_frame_unlocked", int'(locked), 0);

    $display("[TB] short last line coincident with VS");
    sendFrame(V, -1, 0, 1'b0);
    ew_cnt = 0; eh_cnt = 0;
    sendFrame(V, V - 1, H - 1, 1'b1);
    checkVal("coincide_err_width", ew_cnt, 0);
    checkVal("coincide_err_height", eh_cnt, 0);
    checkVal("coincide_meas_width", int'(meas_width), H - 1);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("coincide_good_cnt_cleared", int'(locked), 0);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("coincide_relock", int'(locked), 1);

    $display("[TB] reset mid-frame while locked");
    sendLine(H, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hC3);
    checkVal("rst_out_de", int'(out_de), 0);
    checkVal("rst_out_r", int'(out_r), 0);
    checkVal("rst_locked", int'(locked), 0);
    checkVal("rst_meas_height", int'(meas_height), 0);
    sendFrame(2, -1, 0, 1'b0);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("rst_relock_1", int'(locked), 0);
    sendFrame(V, -1, 0, 1'b0);
    checkVal("rst_relock_2", int'(locked), 1);

    $display("[TB] long DE saturation");
    sendLine(5000, 0);
    checkVal("sat_out_x", int'(out_x), 4095);
    applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
    checkVal("sat_meas_width", int'(meas_width), 4095);
    checkVal("sat_err_width", int'(err_width), 1);

    $display("[TB] random frames");
    for (int f = 0; f < 150; f++) begin
      if ($urandom_range(0, 29) == 0) applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
      randomFrame();
    end
    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 99) == 0, $urandom_range(0, 1) == 1,
                    $urandom_range(0, 3) != 0, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
